// File: rtl/multicycle_fsm_pkg.sv
// multicycle_fsm_pkg: rv32i opcode constants, FSM state encodings and per-state control words
package multicycle_fsm_pkg;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_L   = 7'b0000011;
  localparam logic [6:0] OP_S   = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTER = 4'd6,
    S_EXECUTEI = 4'd7,
    S_ALUWB    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10
  } state_t;

  typedef struct packed {
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       ir_write;
    logic       mem_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
  } ctrl_t;

  // Moore control word; anything not set for a state stays 0
  function automatic ctrl_t state_ctrl(input state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.ir_write   = 1'b1;
        c.alu_src_b  = 2'b10;
        c.result_src = 2'b10;
        c.pc_update  = 1'b1;
      end
      S_DECODE: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
      end
      S_MEMREAD: c.adr_src = 1'b1;
      S_MEMWB: begin
        c.result_src = 2'b01;
        c.reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        c.adr_src   = 1'b1;
        c.mem_write = 1'b1;
      end
      S_EXECUTER: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b10;
      end
      S_EXECUTEI: begin
        c.alu_src_a = 2'b10;
        c.alu_src_b = 2'b01;
        c.alu_op    = 2'b10;
      end
      S_ALUWB: c.reg_write = 1'b1;
      S_BEQ: begin
        c.alu_src_a = 2'b10;
        c.alu_op    = 2'b01;
        c.branch    = 1'b1;
      end
      S_JAL: begin
        c.alu_src_a = 2'b01;
        c.alu_src_b = 2'b10;
        c.pc_update = 1'b1;
      end
      default: c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_fsm_imm_decoder.sv
// imm_decoder: opcode to immediate format select, non-immediate opcodes map to I
module imm_decoder
  import multicycle_fsm_pkg::*;
(
  input  logic [6:0] i_op,
  output logic [1:0] o_imm_src
);

  always_comb o_imm_src = i_op == OP_S   ? IMM_S :
                          i_op == OP_B   ? IMM_B :
                          i_op == OP_JAL ? IMM_J : IMM_I;

endmodule

// File: rtl/multicycle_fsm.sv
// multicycle_fsm: rv32i multicycle control unit, Moore outputs plus branch-qualified pc_write
module multicycle_fsm
  import multicycle_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] imm_src,
  output logic [3:0] state
);

  state_t r_state;
  state_t w_next;
  ctrl_t  w_ctrl;

  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= S_FETCH;
    else      r_state <= w_next;

  always_comb begin
    w_next = S_FETCH;
    w_ctrl = state_ctrl(r_state);
    case (r_state)
      S_FETCH:    w_next = S_DECODE;
      S_DECODE:   w_next = (op == OP_L || op == OP_S) ? S_MEMADR :
                           op == OP_R   ? S_EXECUTER :
                           op == OP_I   ? S_EXECUTEI :
                           op == OP_B   ? S_BEQ :
                           op == OP_JAL ? S_JAL : S_FETCH;
      S_MEMADR:   w_next = op == OP_L ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next = S_MEMWB;
      S_EXECUTER: w_next = S_ALUWB;
      S_EXECUTEI: w_next = S_ALUWB;
      S_JAL:      w_next = S_ALUWB;
      default:    w_next = S_FETCH;
    endcase
  end

  assign pc_write   = w_ctrl.pc_update | (w_ctrl.branch & zero);
  assign adr_src    = w_ctrl.adr_src;
  assign ir_write   = w_ctrl.ir_write;
  assign mem_write  = w_ctrl.mem_write;
  assign reg_write  = w_ctrl.reg_write;
  assign result_src = w_ctrl.result_src;
  assign alu_src_a  = w_ctrl.alu_src_a;
  assign alu_src_b  = w_ctrl.alu_src_b;
  assign alu_op     = w_ctrl.alu_op;
  assign state      = r_state;

  imm_decoder u_imm_decoder (
    .i_op      (op),
    .o_imm_src (imm_src)
  );

endmodule

// File: tb/tb_multicycle_fsm.sv
// tb_multicycle_fsm: random instruction streams against an instruction-level control model
module tb_multicycle_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, ir_write, mem_write, reg_write;
  logic [1:0] result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [3:0] state;

  int n_checks = 0;
  int n_fail = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  multicycle_fsm dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero),
    .pc_write(pc_write), .adr_src(adr_src), .ir_write(ir_write),
    .mem_write(mem_write), .reg_write(reg_write), .result_src(result_src),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .imm_src(imm_src), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {pc_update, branch, adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op}
  function automatic logic [13:0] exp_ctrl(input int s);
    case (s)
      0:       return {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b10, 2'b00, 2'b10, 2'b00};
      1:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 2'b00};
      2:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b00};
      3:       return {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      4:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 2'b00, 2'b00};
      5:       return {1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 2'b00};
      6:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b10};
      7:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 2'b10};
      8:       return {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 2'b00};
      9:       return {1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 2'b01};
      10:      return {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 2'b00};
      default: return 14'd0;
    endcase
  endfunction

  function automatic logic [1:0] exp_imm(input logic [6:0] o);
    return o == 7'b0100011 ? 2'b01 : o == 7'b1100011 ? 2'b10 : o == 7'b1101111 ? 2'b11 : 2'b00;
  endfunction

  function automatic void fill_seq(input logic [6:0] o);
    case (o)
      7'b0000011: exp_q = '{0, 1, 2, 3, 4};
      7'b0100011: exp_q = '{0, 1, 2, 5};
      7'b0110011: exp_q = '{0, 1, 6, 8};
      7'b0010011: exp_q = '{0, 1, 7, 8};
      7'b1100011: exp_q = '{0, 1, 9};
      7'b1101111: exp_q = '{0, 1, 10, 8};
      default:    exp_q = '{0, 1};
    endcase
  endfunction

  task automatic step(input int s);
    logic [13:0] e;
    e = exp_ctrl(s);
    zero = 1'($urandom);
    #1;
    check($sformatf("state op=%b", op), state, s);
    check($sformatf("ctrl s=%0d", s),
          {adr_src, ir_write, mem_write, reg_write, result_src, alu_src_a, alu_src_b, alu_op}, e[11:0]);
    check($sformatf("pc_write s=%0d zero=%b", s, zero), pc_write, e[13] | (e[12] & zero));
    check($sformatf("imm_src op=%b", op), imm_src, exp_imm(op));
    @(posedge clk);
    #1;
  endtask

  task automatic run_instr(input logic [6:0] o);
    op = o;
    fill_seq(o);
    foreach (exp_q[i]) step(exp_q[i]);
  endtask

  logic [6:0] ops[7] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                         7'b1100011, 7'b1101111, 7'b1111111};

  initial begin
    #2;
    check("reset state before any edge", state, 0);
    @(posedge clk);
    #1;
    check("reset state across edge", state, 0);
    check("reset ir_write", ir_write, 1);
    @(negedge clk);
    rst = 1'b1;
    foreach (ops[i]) run_instr(ops[i]);
    for (int k = 0; k < 60; k++) begin
      logic [6:0] o;
      o = $urandom_range(0, 7) == 7 ? 7'($urandom) : ops[$urandom_range(0, 5)];
      run_instr(o);
    end
    op = 7'b0000011;
    step(0);
    step(1);
    step(2);
    check("pre-reset in MEMREAD", state, 3);
    #2;
    rst = 1'b0;
    #1;
    check("async reset state", state, 0);
    check("reset ir_write", ir_write, 1);
    check("reset pc_write", pc_write, 1);
    check("reset no data writes", {mem_write, reg_write}, 0);
    @(posedge clk);
    #1;
    check("reset held over edge", state, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("release ir_write", ir_write, 1);
    check("release pc_write", pc_write, 1);
    @(posedge clk);
    #1;
    check("first edge executes fetch", state, 1);
    step(1);
    step(2);
    step(3);
    step(4);
    for (int k = 0; k < 20; k++) run_instr(ops[$urandom_range(0, 6)]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_fsm.md
MULTICYCLE_FSM -- requirements
Module: multicycle_fsm

Interface
REQ-001 Parameters: none; all encodings are fixed constants.
REQ-002 clk  in  1  single clock; all state changes on rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset (0 = reset).
REQ-004 op  in  7  opcode field of the instruction register.
REQ-005 zero  in  1  ALU zero flag.
REQ-006 pc_write  out  1  PC register enable.
REQ-007 adr_src  out  1  memory address select: 0 = PC, 1 = ALU result register.
REQ-008 ir_write  out  1  instruction register enable.
REQ-009 mem_write  out  1  data memory write enable.
REQ-010 reg_write  out  1  register file write enable.
REQ-011 result_src  out  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
REQ-012 alu_src_a  out  2  ALU A: 00 = PC, 01 = old PC, 10 = rs1 data.
REQ-013 alu_src_b  out  2  ALU B: 00 = rs2 data, 01 = immediate, 10 = constant 4.
REQ-014 alu_op  out  2  to ALU decoder: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
REQ-015 imm_src  out  2  immediate format: 00 = I, 01 = S, 10 = B, 11 = J.
REQ-016 state  out  4  current state encoding, for debug only.

Function
REQ-017 Supported opcodes: R 0110011, I 0010011, L 0000011, S 0100011, B 1100011, JAL 1101111.
REQ-018 States and encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10.
REQ-019 Every output not listed for a state SHALL be 0 in that state.
REQ-020 FETCH: adr_src=0, ir_write=1, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10, pc_update=1; next state DECODE.
REQ-021 DECODE: alu_src_a=01, alu_src_b=01, alu_op=00.
REQ-022 DECODE next state: L or S -> MEMADR; R -> EXECUTER; I -> EXECUTEI; B -> BEQ; JAL -> JAL; any other opcode -> FETCH (no architectural side effect).
REQ-023 MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next state MEMREAD if op=L, else MEMWRITE.
REQ-024 MEMREAD: result_src=00, adr_src=1; next state MEMWB.
REQ-025 MEMWB: result_src=01, reg_write=1; next state FETCH.
REQ-026 MEMWRITE: result_src=00, adr_src=1, mem_write=1; next state FETCH.
REQ-027 EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10; next state ALUWB.
REQ-028 EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10; next state ALUWB.
REQ-029 ALUWB: result_src=00, reg_write=1; next state FETCH.
REQ-030 BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1; next state FETCH.
REQ-031 JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1; next state ALUWB.
REQ-032 pc_write = pc_update OR (branch AND zero), combinational; zero affects only pc_write, only in BEQ.
REQ-033 All other outputs are Moore outputs (functions of state only); imm_src is a combinational function of op only, with non-imm opcodes -> 00.
REQ-034 Cycles per instruction including FETCH: lw 5, sw 4, R 4, I 4, jal 4, beq 3, unsupported 2.

Reset
REQ-035 While rst=0, state SHALL be FETCH asynchronously, independent of clk.
REQ-036 Reset asserted mid-instruction abandons it; no write enable other than FETCH's ir_write/pc_write is asserted while rst=0.
REQ-037 The first rising clk after release executes FETCH.

Structure
REQ-038 Opcode constants and state encodings live in the shared rv32i definitions file, used by this block and the existing decoders.
REQ-039 Sub-module imm_decoder (combinational, op -> imm_src) is instantiated inside; state register and next-state/output logic stay in multicycle_fsm.

Verification
REQ-040 rst=0 mid-MEMREAD -> state=0 immediately; after release, cycle 1 shows ir_write=1, pc_write=1.
REQ-041 op=0000011 -> state sequence 0,1,2,3,4,0; reg_write=1 only in state 4, result_src=01 there.
REQ-042 op=0100011 -> 0,1,2,5,0; mem_write=1 only in state 5, with adr_src=1 and imm_src=01 throughout.
REQ-043 op=1100011 with zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; alu_op=01 in both cases; zero toggled in other states never changes pc_write.
REQ-044 op=1101111 -> 0,1,10,8,0; pc_write=1 in states 0 and 10; reg_write=1 in state 8; imm_src=11.
REQ-045 op=1111111 -> 0,1,0; reg_write, mem_write and branch stay 0 throughout.
